deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_pkg.sv | 16 +
 rtl/des_fifo.sv | 72 +++++++
 rtl/deserializer.sv | 145 ++++++++++++++
 tb/tb_deserializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared constants and state encoding for the serial-to-parallel deserializer.
//   DES_DATA_W     - default parallel word width
//   DES_FIFO_DEPTH - default output buffer depth (power of two, >= 2)
//   des_state_e    - assembler FSM states (ST_PARITY only reachable when DES_PARITY_EN is defined)
package deserializer_pkg;

  localparam int unsigned DES_DATA_W     = 8;
  localparam int unsigned DES_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } des_state_e;

endpackage

// File: rtl/des_fifo.sv
// des_fifo: synchronous FIFO holding assembled words.
//   clk, rst_n   - clock, async active-low reset (clears contents, pointers and occupancy)
//   push, wdata  - write request and data; accepted when not full, or when full and popping
//   pop          - read request; ignored when empty
//   rdata        - entry at the head of the queue
//   full, empty  - occupancy status
module des_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/deserializer.sv
// deserializer: assembles LSB-first serial bits into DATA_W-bit words and queues them.
//   clk, rst_n          - clock, async active-low reset
//   ser_data, ser_valid - serial bit and its qualifier
//   frame_start         - marks the qualified bit as bit 0 of a new word (restarts any partial word)
//   par_data, par_valid - head of the output buffer and non-empty flag
//   par_ready           - consumer accept; pops when par_valid is high
//   overflow            - sticky: a completed word was dropped because the buffer was full
//   parity_err          - one-cycle pulse on an even-parity mismatch
// Optional feature: define DES_PARITY_EN to expect one even-parity bit after each word.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned DATA_W     = DES_DATA_W,
  parameter int unsigned FIFO_DEPTH = DES_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_data,
  input  logic              ser_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] par_data,
  output logic              par_valid,
  input  logic              par_ready,
  output logic              overflow,
  output logic              parity_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  des_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              overflow_q, overflow_d;
  logic              push_c;
  logic [DATA_W-1:0] push_data_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;
`ifdef DES_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  // Word assembly FSM; frame_start always wins and restarts at bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    push_c      = 1'b0;
    push_data_c = word_q;
`ifdef DES_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (ser_valid) begin
      if (frame_start) begin
        state_d = ST_SHIFT;
        cnt_d   = CNT_W'(1);
        word_d  = DATA_W'(ser_data);
      end else begin
        case (state_q)
          ST_SHIFT: begin
            word_d[cnt_q] = ser_data;
            if (cnt_q == LAST_IDX) begin
              cnt_d = '0;
`ifdef DES_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d     = ST_IDLE;
              push_c      = 1'b1;
              push_data_c = word_d;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef DES_PARITY_EN
          // Even parity: the parity bit equals the XOR of the data bits.
          ST_PARITY: begin
            state_d = ST_IDLE;
            if (ser_data == ^word_q) begin
              push_c = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
          end
`endif
          ST_IDLE: begin
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign pop_c      = !fifo_empty && par_ready;
  assign overflow_d = overflow_q | (push_c && fifo_full && !pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DES_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  des_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (push_data_c),
    .pop   (pop_c),
    .rdata (par_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign par_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed test of the deserializer with hand-computed expected words.
// Covers DES_PARITY_EN when the macro is defined for the build.
module tb_deserializer;

`ifdef DES_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_data;
  logic       ser_valid;
  logic       frame_start;
  logic [7:0] par_data;
  logic       par_valid;
  logic       par_ready;
  logic       overflow;
  logic       parity_err;

  int n_chk = 0;
  int n_bad = 0;
  bit par_flip = 1'b0;

  always #5 clk = ~clk;

  deserializer #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .par_data    (par_data),
    .par_valid   (par_valid),
    .par_ready   (par_ready),
    .overflow    (overflow),
    .parity_err  (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic fs);
    @(negedge clk);
    ser_valid   = 1'b1;
    ser_data    = b;
    frame_start = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      ser_data    = 1'b0;
    end
  endtask

  // Sends one word (plus parity bit when enabled); returns at the negedge after the last bit.
  task automatic send_word(input logic [7:0] d, input int gap_after, input bit rdy_last);
    logic [8:0] v;
    v = {(^d) ^ par_flip, d};
    for (int i = 0; i < NBITS; i++) begin
      drive_bit(v[i], logic'(i == 0));
      if (rdy_last && i == NBITS - 1) par_ready = 1'b1;
      if (i == gap_after) begin
        idle(3);
        chk("gap_no_early_word", par_valid, 0);
      end
    end
    @(negedge clk);
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    ser_data    = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    par_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", par_valid, 0);
    chk("rst_data", par_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_perr", parity_err, 0);
    rst_n = 1'b1;
    idle(2);

    // Single word
    par_ready = 1'b1;
    send_word(8'hA5, -1, 1'b0);
    chk("a5_valid", par_valid, 1);
    chk("a5_data", par_data, 8'hA5);
    chk("a5_perr", parity_err, 0);
    @(negedge clk);
    chk("a5_popped", par_valid, 0);

    // Gap of three invalid cycles between bits 2 and 3
    send_word(8'h3C, 2, 1'b0);
    chk("gap_valid", par_valid, 1);
    chk("gap_data", par_data, 8'h3C);
    @(negedge clk);
    idle(4);
    chk("gap_no_extra", par_valid, 0);

    // Resync: 4 partial bits, then a fresh frame
    for (int i = 0; i < 4; i++) drive_bit(1'b1, logic'(i == 0));
    send_word(8'h5A, -1, 1'b0);
    chk("resync_valid", par_valid, 1);
    chk("resync_data", par_data, 8'h5A);
    @(negedge clk);
    chk("resync_one_word", par_valid, 0);

    // Full buffer with simultaneous push and pop
    par_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_word(8'hA0 + 8'(k), -1, 1'b0);
    chk("full_head", par_data, 8'hA1);
    chk("full_ovf", overflow, 0);
    send_word(8'hA5, -1, 1'b1);
    chk("simul_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("simul_order", par_data, 8'hA0 + k);
      @(negedge clk);
    end
    chk("simul_drained", par_valid, 0);

    // Backpressure and overflow
    par_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_word(8'(k), -1, 1'b0);
      if (k == 4) chk("bp_no_ovf_yet", overflow, 0);
    end
    chk("bp_ovf", overflow, 1);
    chk("bp_valid", par_valid, 1);
    par_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_order", par_data, k);
      @(negedge clk);
    end
    chk("bp_drained", par_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // Reset mid-word with two words buffered
    par_ready = 1'b0;
    send_word(8'h11, -1, 1'b0);
    send_word(8'h22, -1, 1'b0);
    chk("pre_rst_head", par_data, 8'h11);
    for (int i = 0; i < 6; i++) drive_bit(logic'(i % 2 == 0), logic'(i == 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", par_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_data", par_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    idle(2);
    chk("post_rst_ignored", par_valid, 0);
    par_ready = 1'b1;
    send_word(8'hFF, -1, 1'b0);
    chk("post_rst_valid", par_valid, 1);
    chk("post_rst_data", par_data, 8'hFF);
    @(negedge clk);
    idle(3);
    chk("post_rst_only", par_valid, 0);

`ifdef DES_PARITY_EN
    par_flip = 1'b0;
    send_word(8'h07, -1, 1'b0);
    chk("par_ok_valid", par_valid, 1);
    chk("par_ok_data", par_data, 8'h07);
    chk("par_ok_perr", parity_err, 0);
    @(negedge clk);
    par_flip = 1'b1;
    send_word(8'h07, -1, 1'b0);
    chk("par_bad_no_push", par_valid, 0);
    chk("par_bad_perr", parity_err, 1);
    @(negedge clk);
    chk("par_bad_pulse_end", parity_err, 0);
    par_flip = 1'b0;
`else
    chk("perr_const", parity_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
